// File: rtl/spaceinvaders_pkg.sv
// Shared playfield constants and state encodings for the space-invaders blocks.
// The player ship block uses the same left/right borders as the laser.
package spaceinvaders_pkg;

    localparam int COORD_W = 10;

    localparam logic [COORD_W-1:0] BORDER_LEFT  = 10'd9;
    localparam logic [COORD_W-1:0] BORDER_RIGHT = 10'd629;
    localparam logic [COORD_W-1:0] BORDER_TOP   = 10'd8;

    // One-hot so the debug port reads directly as a state flag.
    typedef enum logic [2:0] {
        LASER_IDLE     = 3'b001,
        LASER_FLYING   = 3'b010,
        LASER_COOLDOWN = 3'b100
    } laser_state_e;

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter that only advances on unpaused frame ticks and
// saturates at zero; used to time the laser cooldown.
module frame_down_counter #(
    parameter int width_p = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [width_p-1:0] load_value,
    input  logic               frame,
    input  logic               pause,
    input  logic               run,
    output logic               zero
);

    logic [width_p-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (run && frame && !pause && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/player_laser.sv
// Single player laser: spawns at the gun, climbs one step per frame, retires on
// hit or at the top border, then waits a frame-counted cooldown before re-arming.
module player_laser
    import spaceinvaders_pkg::*;
#(
    parameter logic [11:0]        color_p      = {4'hF, 4'hF, 4'hF},
    parameter logic [COORD_W-1:0] spawn_top_p  = 10'd440,
    parameter logic [COORD_W-1:0] height_p     = 10'd10,
    parameter logic [COORD_W-1:0] step_p       = 10'd8,
    parameter logic [COORD_W-1:0] top_border_p = BORDER_TOP,
    parameter logic [3:0]         cooldown_p   = 4'd15
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               frame_i,
    input  logic               fire_i,
    input  logic               alive_i,
    input  logic               pause_i,
    input  logic [COORD_W-1:0] gun_left_i,
    input  logic [COORD_W-1:0] gun_right_i,
    input  logic               hit_i,
    output logic               active_o,
    output logic               shot_laser_o,
    output logic [COORD_W-1:0] laser_left_o,
    output logic [COORD_W-1:0] laser_right_o,
    output logic [COORD_W-1:0] laser_top_o,
    output logic [COORD_W-1:0] laser_bottom_o,
    output logic [3:0]         laser_red_o,
    output logic [3:0]         laser_green_o,
    output logic [3:0]         laser_blue_o,
    output logic [2:0]         state_o
);

    localparam logic [2:0] IDLE     = LASER_IDLE;
    localparam logic [2:0] FLYING   = LASER_FLYING;
    localparam logic [2:0] COOLDOWN = LASER_COOLDOWN;

    logic [2:0]         state_reg, state_next;
    logic [COORD_W-1:0] left_reg, left_next;
    logic [COORD_W-1:0] right_reg, right_next;
    logic [COORD_W-1:0] top_reg, top_next;
    logic               shot_reg, shot_next;
    logic               cool_load;
    logic               cool_zero;

    logic fire_ok;
    logic move_tick;

    assign fire_ok   = fire_i & alive_i & ~pause_i;
    assign move_tick = frame_i & ~pause_i;

    always_comb begin
        state_next = state_reg;
        left_next  = left_reg;
        right_next = right_reg;
        top_next   = top_reg;
        shot_next  = 1'b0;
        cool_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fire_ok) begin
                    state_next = FLYING;
                    left_next  = gun_left_i;
                    right_next = gun_right_i;
                    top_next   = spawn_top_p;
                    shot_next  = 1'b1;
                end
            end
            FLYING: begin
                if (!alive_i) begin
                    state_next = IDLE;
                    left_next  = '0;
                    right_next = '0;
                    top_next   = '0;
                end else if (hit_i) begin
                    state_next = COOLDOWN;
                    cool_load  = 1'b1;
                end else if (move_tick) begin
                    // Retiring before the subtract keeps top from ever wrapping.
                    if (top_reg < top_border_p + step_p) begin
                        state_next = COOLDOWN;
                        cool_load  = 1'b1;
                    end else begin
                        top_next = top_reg - step_p;
                    end
                end
            end
            COOLDOWN: begin
                if (cool_zero) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= IDLE;
            left_reg  <= '0;
            right_reg <= '0;
            top_reg   <= '0;
            shot_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            left_reg  <= left_next;
            right_reg <= right_next;
            top_reg   <= top_next;
            shot_reg  <= shot_next;
        end
    end

    frame_down_counter #(
        .width_p(4)
    ) cooldown_counter (
        .clk        (clk_i),
        .rst        (reset_i),
        .load       (cool_load),
        .load_value (cooldown_p),
        .frame      (frame_i),
        .pause      (pause_i),
        .run        (state_reg == COOLDOWN),
        .zero       (cool_zero)
    );

    assign active_o       = (state_reg == FLYING);
    assign shot_laser_o   = shot_reg;
    assign laser_left_o   = active_o ? left_reg : '0;
    assign laser_right_o  = active_o ? right_reg : '0;
    assign laser_top_o    = active_o ? top_reg : '0;
    assign laser_bottom_o = active_o ? (top_reg + height_p - 10'd1) : '0;
    assign laser_red_o    = color_p[11:8];
    assign laser_green_o  = color_p[7:4];
    assign laser_blue_o   = color_p[3:0];
    assign state_o        = state_reg;

endmodule

// File: tb/tb_player_laser.sv
// Bench for player_laser: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_player_laser;

    localparam int SPAWN    = 440;
    localparam int HEIGHT   = 10;
    localparam int STEP     = 8;
    localparam int BORDER   = 8;
    localparam int COOLDOWN = 15;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       frame_i = 1'b0;
    logic       fire_i = 1'b0;
    logic       alive_i = 1'b1;
    logic       pause_i = 1'b0;
    logic [9:0] gun_left_i = 10'd0;
    logic [9:0] gun_right_i = 10'd0;
    logic       hit_i = 1'b0;
    logic       active_o, shot_laser_o;
    logic [9:0] laser_left_o, laser_right_o, laser_top_o, laser_bottom_o;
    logic [3:0] laser_red_o, laser_green_o, laser_blue_o;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    player_laser dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .fire_i         (fire_i),
        .alive_i        (alive_i),
        .pause_i        (pause_i),
        .gun_left_i     (gun_left_i),
        .gun_right_i    (gun_right_i),
        .hit_i          (hit_i),
        .active_o       (active_o),
        .shot_laser_o   (shot_laser_o),
        .laser_left_o   (laser_left_o),
        .laser_right_o  (laser_right_o),
        .laser_top_o    (laser_top_o),
        .laser_bottom_o (laser_bottom_o),
        .laser_red_o    (laser_red_o),
        .laser_green_o  (laser_green_o),
        .laser_blue_o   (laser_blue_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting to fire, 1 = laser in the air, 2 = recharging.
    int m_mode = 0;
    int m_left = 0, m_right = 0, m_top = 0;
    int m_frames_left = 0;
    bit m_shot = 1'b0;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_mode        <= 0;
            m_left        <= 0;
            m_right       <= 0;
            m_top         <= 0;
            m_frames_left <= 0;
            m_shot        <= 1'b0;
        end else begin
            m_shot <= 1'b0;
            if (m_mode == 0) begin
                if (fire_i && alive_i && !pause_i) begin
                    m_mode  <= 1;
                    m_left  <= int'(gun_left_i);
                    m_right <= int'(gun_right_i);
                    m_top   <= SPAWN;
                    m_shot  <= 1'b1;
                end
            end else if (m_mode == 1) begin
                if (!alive_i) begin
                    m_mode <= 0;
                end else if (hit_i) begin
                    m_mode        <= 2;
                    m_frames_left <= COOLDOWN;
                end else if (frame_i && !pause_i) begin
                    // Leave when another step would cross the top border.
                    if (m_top - STEP < BORDER) begin
                        m_mode        <= 2;
                        m_frames_left <= COOLDOWN;
                    end else begin
                        m_top <= m_top - STEP;
                    end
                end
            end else begin
                if (m_frames_left == 0) m_mode <= 0;
                else if (frame_i && !pause_i) m_frames_left <= m_frames_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        automatic bit flying = (m_mode == 1);
        chk("state", int'(state_o), 1 << m_mode);
        chk("active", int'(active_o), int'(flying));
        chk("shot", int'(shot_laser_o), int'(m_shot));
        chk("left", int'(laser_left_o), flying ? m_left : 0);
        chk("right", int'(laser_right_o), flying ? m_right : 0);
        chk("top", int'(laser_top_o), flying ? m_top : 0);
        chk("bottom", int'(laser_bottom_o), flying ? m_top + HEIGHT - 1 : 0);
        chk("colour", int'({laser_red_o, laser_green_o, laser_blue_o}), 12'hFFF);
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_i = 1'b1;
            cycle();
            frame_i = 1'b0;
        end
    endtask

    initial begin
        int shots;
        cycle();
        cycle();
        chk("reset_state", int'(state_o), 3'b001);
        chk("reset_active", int'(active_o), 0);
        chk("reset_top", int'(laser_top_o), 0);
        reset_i = 1'b0;

        // Spawn with fire held throughout the first flight and cooldown.
        gun_left_i  = 10'd264;
        gun_right_i = 10'd274;
        fire_i      = 1'b1;
        cycle();
        chk("spawn_shot", int'(shot_laser_o), 1);
        chk("spawn_left", int'(laser_left_o), 264);
        chk("spawn_right", int'(laser_right_o), 274);
        chk("spawn_top", int'(laser_top_o), 440);
        chk("spawn_bottom", int'(laser_bottom_o), 449);
        cycle();
        chk("shot_one_cycle", int'(shot_laser_o), 0);
        shots = 0;
        for (int i = 0; i < 54; i++) begin
            tick(1);
            shots += int'(shot_laser_o);
        end
        chk("top_after_54", int'(laser_top_o), 8);
        tick(1);
        chk("retire_active", int'(active_o), 0);
        chk("retire_state", int'(state_o), 3'b100);
        for (int i = 0; i < 15; i++) begin
            tick(1);
            shots += int'(shot_laser_o);
        end
        chk("no_shot_while_held", shots, 0);
        chk("cooldown_end_state", int'(state_o), 3'b100);
        cycle();
        chk("idle_after_cooldown", int'(state_o), 3'b001);
        cycle();
        chk("held_fire_reshot", int'(shot_laser_o), 1);
        fire_i = 1'b0;

        // Hit between frames at top 200.
        tick(30);
        chk("top_200", int'(laser_top_o), 200);
        hit_i = 1'b1;
        cycle();
        hit_i = 1'b0;
        chk("hit_state", int'(state_o), 3'b100);
        chk("hit_top_zero", int'(laser_top_o), 0);
        tick(15);
        cycle();

        // Pause freezes motion.
        fire_i = 1'b1;
        cycle();
        fire_i = 1'b0;
        tick(17);
        chk("top_304", int'(laser_top_o), 304);
        pause_i = 1'b1;
        tick(10);
        chk("paused_top", int'(laser_top_o), 304);
        pause_i = 1'b0;
        tick(1);
        chk("resumed_top", int'(laser_top_o), 296);
        hit_i = 1'b1;
        cycle();
        hit_i = 1'b0;
        tick(15);
        cycle();

        // Asynchronous reset mid-flight, then alive drop.
        fire_i = 1'b1;
        cycle();
        fire_i = 1'b0;
        tick(3);
        #2 reset_i = 1'b1;
        #1 chk("async_reset_state", int'(state_o), 3'b001);
        chk("async_reset_active", int'(active_o), 0);
        @(negedge clk);
        reset_i = 1'b0;
        fire_i  = 1'b1;
        cycle();
        chk("fire_after_reset", int'(shot_laser_o), 1);
        alive_i = 1'b0;
        cycle();
        chk("dead_state", int'(state_o), 3'b001);
        alive_i = 1'b1;
        cycle();
        chk("fire_after_death", int'(shot_laser_o), 1);
        fire_i = 1'b0;

        // Random traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 reset_i = 1'b1;
                @(negedge clk);
                reset_i = 1'b0;
            end
            frame_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) fire_i = ~fire_i;
            if ($urandom_range(0, 59) == 0) alive_i = ~alive_i;
            if ($urandom_range(0, 39) == 0) pause_i = ~pause_i;
            hit_i = ($urandom_range(0, 24) == 0);
            gun_left_i  = 10'($urandom_range(9, 619));
            gun_right_i = gun_left_i + 10'd10;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
